// File: rtl/irq_seq.sv
// Interrupt entry/return sequencer: pushes PC/SR, clears SR, loads the vector, and unwinds on RETI.
// Optional build macro IRQ_NMI_EN adds an edge-triggered non-maskable request (nmi_req/nmi_ack).
module irq_seq #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               insn_boundary,
  input  logic               reti_req,
  input  logic [15:0]        pc_in,
  input  logic [15:0]        sp_in,
  input  logic [15:0]        sr_in,
  output logic               rf_RW,
  output logic [3:0]         rf_DA,
  output logic [15:0]        rf_Din,
  output logic [15:0]        mem_addr,
  output logic [15:0]        mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [15:0]        mem_rdata,
  input  logic               mem_rdy,
`ifdef IRQ_NMI_EN
  input  logic               nmi_req,
  output logic               nmi_ack,
`endif
  output logic               busy
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [3:0] {
    IDLE, PUSH_PC, PUSH_SR, CLR_SR, VEC_RD, LOAD_PC, POP_SR, INC_SP1, POP_PC, INC_SP2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] hi_idx;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      sp_dec, sp_inc, vec_addr;
  logic             nmi_sel;

  assign sp_dec = sp_in - 16'd2;
  assign sp_inc = sp_in + 16'd2;

`ifdef IRQ_NMI_EN
  logic nmi_prev_q, nmi_pend_q, nmi_pend_d, nmi_sel_q, nmi_sel_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_sel_q  <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_req;
      nmi_pend_q <= nmi_pend_d;
      nmi_sel_q  <= nmi_sel_d;
    end
  end

  assign nmi_sel = nmi_sel_q;
  assign nmi_ack = (state_q == CLR_SR) && nmi_sel_q;
`else
  assign nmi_sel = 1'b0;
`endif

  // Highest set index wins, so later loop iterations override earlier ones.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_req[i]) hi_idx = IDX_W'(i);
    end
  end

  assign vec_addr = nmi_sel ? 16'hFFFC : (VEC_BASE + (16'(idx_q) << 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    irq_ack   = '0;
    rf_RW     = 1'b0;
    rf_DA     = 4'd0;
    rf_Din    = 16'h0000;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    busy      = (state_q != IDLE);
`ifdef IRQ_NMI_EN
    nmi_pend_d = nmi_pend_q | (nmi_req & ~nmi_prev_q);
    nmi_sel_d  = nmi_sel_q;
`endif

    case (state_q)
      IDLE: begin
        // RETI outranks any pending request; requests are re-examined once back here.
        if (reti_req) begin
          state_d = POP_SR;
`ifdef IRQ_NMI_EN
        end else if (insn_boundary && nmi_pend_q) begin
          state_d    = PUSH_PC;
          nmi_sel_d  = 1'b1;
          nmi_pend_d = nmi_req & ~nmi_prev_q;
`endif
        end else if (insn_boundary && (|irq_req) && sr_in[3]) begin
          state_d = PUSH_PC;
          idx_d   = hi_idx;
`ifdef IRQ_NMI_EN
          nmi_sel_d = 1'b0;
`endif
        end
      end
      PUSH_PC: begin
        mem_we    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = pc_in;
        if (mem_rdy) begin
          rf_RW   = 1'b1;
          rf_DA   = 4'd1;
          rf_Din  = sp_dec;
          state_d = PUSH_SR;
        end
      end
      PUSH_SR: begin
        mem_we    = 1'b1;
        mem_addr  = sp_dec;
        mem_wdata = sr_in;
        if (mem_rdy) begin
          rf_RW   = 1'b1;
          rf_DA   = 4'd1;
          rf_Din  = sp_dec;
          state_d = CLR_SR;
        end
      end
      CLR_SR: begin
        rf_RW   = 1'b1;
        rf_DA   = 4'd2;
        rf_Din  = sr_in & 16'hFF47;
        if (!nmi_sel) irq_ack[idx_q] = 1'b1;
        state_d = VEC_RD;
      end
      VEC_RD: begin
        mem_re   = 1'b1;
        mem_addr = vec_addr;
        if (mem_rdy) begin
          vec_d   = mem_rdata;
          state_d = LOAD_PC;
        end
      end
      LOAD_PC: begin
        rf_RW   = 1'b1;
        rf_DA   = 4'd0;
        rf_Din  = vec_q & 16'hFFFE;
        state_d = IDLE;
      end
      POP_SR: begin
        mem_re   = 1'b1;
        mem_addr = sp_in;
        if (mem_rdy) begin
          rf_RW   = 1'b1;
          rf_DA   = 4'd2;
          rf_Din  = mem_rdata;
          state_d = INC_SP1;
        end
      end
      INC_SP1: begin
        rf_RW   = 1'b1;
        rf_DA   = 4'd1;
        rf_Din  = sp_inc;
        state_d = POP_PC;
      end
      POP_PC: begin
        mem_re   = 1'b1;
        mem_addr = sp_in;
        if (mem_rdy) begin
          rf_RW   = 1'b1;
          rf_DA   = 4'd0;
          rf_Din  = mem_rdata & 16'hFFFE;
          state_d = INC_SP2;
        end
      end
      INC_SP2: begin
        rf_RW   = 1'b1;
        rf_DA   = 4'd1;
        rf_Din  = sp_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_seq.sv
// Directed self-checking bench for irq_seq: entry, RETI, stalls, reset abort, SP wrap and (with IRQ_NMI_EN) NMI.
// A small register-file and memory model closes the loop so SP/SR/PC feed back as on the real CPU.
module tb_irq_seq;

   logic        clk;
   logic        rst;
   logic [3:0]  irqReq;
   logic [3:0]  irqAck;
   logic        insnBoundary;
   logic        retiReq;
   logic [15:0] r0, r1, r2;
   logic        rfRw;
   logic [3:0]  rfDa;
   logic [15:0] rfDin;
   logic [15:0] memAddr, memWdata, memRdata;
   logic        memWe, memRe, memRdy;
   logic        busy;
`ifdef IRQ_NMI_EN
   logic        nmiReq;
   logic        nmiAck;
`endif

   logic        presetEn;
   logic [15:0] presetPc, presetSp, presetSr;
   logic [15:0] memArr [0:65535];

   int checkCount;
   int errorCount;

   irq_seq dut (
      .clk           (clk),
      .rst           (rst),
      .irq_req       (irqReq),
      .irq_ack       (irqAck),
      .insn_boundary (insnBoundary),
      .reti_req      (retiReq),
      .pc_in         (r0),
      .sp_in         (r1),
      .sr_in         (r2),
      .rf_RW         (rfRw),
      .rf_DA         (rfDa),
      .rf_Din        (rfDin),
      .mem_addr      (memAddr),
      .mem_wdata     (memWdata),
      .mem_we        (memWe),
      .mem_re        (memRe),
      .mem_rdata     (memRdata),
      .mem_rdy       (memRdy),
`ifdef IRQ_NMI_EN
      .nmi_req       (nmiReq),
      .nmi_ack       (nmiAck),
`endif
      .busy          (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: R0..R2 are written by the DUT, or preloaded by the bench between tests.
   always @(posedge clk) begin
      if (presetEn) begin
         r0 <= presetPc;
         r1 <= presetSp;
         r2 <= presetSr;
      end else if (rfRw) begin
         case (rfDa)
            4'd0: r0 <= rfDin;
            4'd1: r1 <= rfDin;
            4'd2: r2 <= rfDin;
            default: ;
         endcase
      end
   end

   // Memory model: stack writes land in memArr only on a completed handshake.
   always @(posedge clk) begin
      if (memWe && memRdy) memArr[memAddr] <= memWdata;
   end

   // Vector table is fixed content; everything else reads back the stack array.
   always_comb begin
      case (memAddr)
         16'hFFE2: memRdata = 16'h4443;
         16'hFFE4: memRdata = 16'hC2A5;
         16'hFFE6: memRdata = 16'h5A5B;
         16'hFFFC: memRdata = 16'h8123;
         default:  memRdata = memArr[memAddr];
      endcase
   end

   // Single comparison point: counts every check and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Memory strobe pair plus address.
   task automatic checkMem(input string tag, input logic we, input logic re, input logic [15:0] addr);
      checkOutput({tag, "_we"}, 16'(memWe), 16'(we));
      checkOutput({tag, "_re"}, 16'(memRe), 16'(re));
      checkOutput({tag, "_addr"}, memAddr, addr);
   endtask

   // Register-file write port; destination and data only matter when a write is expected.
   task automatic checkRf(input string tag, input logic rw, input logic [3:0] da, input logic [15:0] din);
      checkOutput({tag, "_rw"}, 16'(rfRw), 16'(rw));
      if (rw) begin
         checkOutput({tag, "_da"}, 16'(rfDa), 16'(da));
         checkOutput({tag, "_din"}, rfDin, din);
      end
   endtask

   // Drive request-side inputs; called just after a falling edge so they are stable at the next rising edge.
   task automatic applyStimulus(input logic [3:0] irq, input logic boundary, input logic reti, input logic rdy);
      irqReq       = irq;
      insnBoundary = boundary;
      retiReq      = reti;
      memRdy       = rdy;
      #1;
   endtask

   // Advance one clock and sample on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Load R0/R1/R2 through the model's preset path, taking one clock.
   task automatic presetRegs(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] sr);
      presetPc = pc;
      presetSp = sp;
      presetSr = sr;
      presetEn = 1'b1;
      step();
      presetEn = 1'b0;
   endtask

   // Directed test sequence with hand-computed expectations.
   initial begin
      checkCount   = 0;
      errorCount   = 0;
      rst          = 1'b0;
      presetEn     = 1'b0;
      presetPc     = 16'h0000;
      presetSp     = 16'h0000;
      presetSr     = 16'h0000;
`ifdef IRQ_NMI_EN
      nmiReq       = 1'b0;
`endif
      @(negedge clk);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      step();
      checkOutput("rst_busy", 16'(busy), 16'h0);
      checkMem("rst", 1'b0, 1'b0, 16'h0000);
      checkRf("rst", 1'b0, 4'd0, 16'h0000);
      checkOutput("rst_ack", 16'(irqAck), 16'h0);
      rst = 1'b1;

      // Basic entry: lines 0 and 2 requesting, line 2 wins; request drops right after acceptance.
      presetRegs(16'hC010, 16'h0400, 16'h0008);
      applyStimulus(4'b0101, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("t1_pushpc_busy", 16'(busy), 16'h1);
      checkMem("t1_pushpc", 1'b1, 1'b0, 16'h03FE);
      checkOutput("t1_pushpc_wd", memWdata, 16'hC010);
      checkRf("t1_pushpc", 1'b1, 4'd1, 16'h03FE);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      checkMem("t1_pushsr", 1'b1, 1'b0, 16'h03FC);
      checkOutput("t1_pushsr_wd", memWdata, 16'h0008);
      checkRf("t1_pushsr", 1'b1, 4'd1, 16'h03FC);
      step();
      checkRf("t1_clrsr", 1'b1, 4'd2, 16'h0000);
      checkOutput("t1_clrsr_ack", 16'(irqAck), 16'h0004);
      step();
      checkMem("t1_vecrd", 1'b0, 1'b1, 16'hFFE4);
      checkRf("t1_vecrd", 1'b0, 4'd0, 16'h0000);
      checkOutput("t1_vecrd_ack", 16'(irqAck), 16'h0);
      step();
      checkOutput("t1_loadpc_busy", 16'(busy), 16'h1);
      checkRf("t1_loadpc", 1'b1, 4'd0, 16'hC2A4);
      step();
      checkOutput("t1_idle_busy", 16'(busy), 16'h0);
      checkOutput("t1_r0", r0, 16'hC2A4);
      checkOutput("t1_r1", r1, 16'h03FC);
      checkOutput("t1_r2", r2, 16'h0000);
      checkOutput("t1_stk_pc", memArr[16'h03FE], 16'hC010);
      checkOutput("t1_stk_sr", memArr[16'h03FC], 16'h0008);

      // GIE clear: request is ignored, nothing moves.
      presetRegs(16'hC010, 16'h0400, 16'h0000);
      applyStimulus(4'b0101, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("t2_busy", 16'(busy), 16'h0);
      checkMem("t2", 1'b0, 1'b0, 16'h0000);
      checkRf("t2", 1'b0, 4'd0, 16'h0000);
      step();
      checkOutput("t2_busy2", 16'(busy), 16'h0);

      // RETI with a qualified irq in the same cycle: RETI wins, unwinds the frame from test 1.
      presetRegs(16'h1234, 16'h03FC, 16'h0008);
      applyStimulus(4'b1000, 1'b1, 1'b1, 1'b1);
      step();
      checkMem("t3_popsr", 1'b0, 1'b1, 16'h03FC);
      checkRf("t3_popsr", 1'b1, 4'd2, 16'h0008);
      checkOutput("t3_popsr_ack", 16'(irqAck), 16'h0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      checkRf("t3_incsp1", 1'b1, 4'd1, 16'h03FE);
      step();
      checkMem("t3_poppc", 1'b0, 1'b1, 16'h03FE);
      checkRf("t3_poppc", 1'b1, 4'd0, 16'hC010);
      step();
      checkRf("t3_incsp2", 1'b1, 4'd1, 16'h0400);
      checkOutput("t3_incsp2_busy", 16'(busy), 16'h1);
      step();
      checkOutput("t3_idle_busy", 16'(busy), 16'h0);
      checkOutput("t3_r0", r0, 16'hC010);
      checkOutput("t3_r1", r1, 16'h0400);
      checkOutput("t3_r2", r2, 16'h0008);

      // Stall PUSH_PC for three cycles, then check SR masking, then reset during VEC_RD.
      presetRegs(16'hC010, 16'h0400, 16'h00F8);
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checkMem("t4_stall", 1'b1, 1'b0, 16'h03FE);
         checkOutput("t4_stall_wd", memWdata, 16'hC010);
         checkRf("t4_stall", 1'b0, 4'd0, 16'h0000);
         if (i < 2) step();
      end
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      checkRf("t4_rdy", 1'b1, 4'd1, 16'h03FE);
      step();
      checkMem("t4_pushsr", 1'b1, 1'b0, 16'h03FC);
      checkOutput("t4_pushsr_wd", memWdata, 16'h00F8);
      step();
      checkRf("t4_clrsr", 1'b1, 4'd2, 16'h0040);
      checkOutput("t4_clrsr_ack", 16'(irqAck), 16'h0002);
      step();
      checkMem("t4_vecrd", 1'b0, 1'b1, 16'hFFE2);
      rst = 1'b0;
      step();
      checkOutput("t5_rst_busy", 16'(busy), 16'h0);
      checkMem("t5_rst", 1'b0, 1'b0, 16'h0000);
      checkRf("t5_rst", 1'b0, 4'd0, 16'h0000);
      checkOutput("t5_rst_ack", 16'(irqAck), 16'h0);
      rst = 1'b1;
      step();
      checkOutput("t5_after_busy", 16'(busy), 16'h0);
      checkRf("t5_after", 1'b0, 4'd0, 16'h0000);
      checkOutput("t5_r0_kept", r0, 16'hC010);

      // SP wrap below zero, highest line, odd vector content.
      presetRegs(16'hABCD, 16'h0000, 16'h0008);
      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1);
      step();
      checkMem("t6_pushpc", 1'b1, 1'b0, 16'hFFFE);
      checkRf("t6_pushpc", 1'b1, 4'd1, 16'hFFFE);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      checkMem("t6_pushsr", 1'b1, 1'b0, 16'hFFFC);
      checkRf("t6_pushsr", 1'b1, 4'd1, 16'hFFFC);
      step();
      checkOutput("t6_ack", 16'(irqAck), 16'h0008);
      step();
      checkMem("t6_vecrd", 1'b0, 1'b1, 16'hFFE6);
      step();
      checkRf("t6_loadpc", 1'b1, 4'd0, 16'h5A5A);
      step();
      checkOutput("t6_idle_busy", 16'(busy), 16'h0);

`ifdef IRQ_NMI_EN
      // NMI edge with GIE clear and a competing irq: edge registers first, then NMI entry.
      presetRegs(16'hC010, 16'h0400, 16'h0000);
      nmiReq = 1'b1;
      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("t7_edge_busy", 16'(busy), 16'h0);
      step();
      checkMem("t7_pushpc", 1'b1, 1'b0, 16'h03FE);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      step();
      checkOutput("t7_nmi_ack", 16'(nmiAck), 16'h1);
      checkOutput("t7_irq_ack", 16'(irqAck), 16'h0);
      step();
      checkMem("t7_vecrd", 1'b0, 1'b1, 16'hFFFC);
      step();
      checkRf("t7_loadpc", 1'b1, 4'd0, 16'h8122);
      step();
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
      step();
      checkOutput("t7_no_repeat", 16'(busy), 16'h0);
      nmiReq = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/irq_seq.md
IRQ_SEQ -- requirements
Module: irq_seq

Interface
REQ-001 NUM_IRQ, 4, maskable request lines (1..8).
REQ-002 VEC_BASE, 16'hFFE0, vector address of line i = VEC_BASE + 2*i.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 irq_req  in  NUM_IRQ  level requests; higher index = higher priority.
REQ-006 irq_ack  out  NUM_IRQ  one-hot single-cycle acknowledge.
REQ-007 insn_boundary  in  1  CPU at instruction boundary; interrupt entry permitted.
REQ-008 reti_req  in  1  RETI decoded; start return sequence.
REQ-009 pc_in, sp_in, sr_in  in  16 each  current R0, R1, R2 from register file.
REQ-010 rf_RW  out  1; rf_DA  out  4; rf_Din  out  16  register-file write port.
REQ-011 mem_addr  out  16; mem_wdata  out  16; mem_we, mem_re  out  1; mem_rdata  in  16; mem_rdy  in  1  memory handshake.
REQ-012 busy  out  1  high in every state except IDLE; stalls fetch.

Function
REQ-013 States: IDLE, PUSH_PC, PUSH_SR, CLR_SR, VEC_RD, LOAD_PC, POP_SR, INC_SP1, POP_PC, INC_SP2.
REQ-014 IDLE: reti_req=1 -> POP_SR; else insn_boundary=1, |irq_req, sr_in[3] (GIE)=1 -> latch highest-index active line, go PUSH_PC.
REQ-015 reti_req and a qualified irq in the same cycle: RETI wins; irq is re-evaluated on return to IDLE.
REQ-016 PUSH_PC: mem_we=1, mem_addr=sp_in-2, mem_wdata=pc_in, held until mem_rdy; the mem_rdy cycle also drives rf_RW=1, rf_DA=1, rf_Din=sp_in-2 -> PUSH_SR.
REQ-017 PUSH_SR: as PUSH_PC with mem_wdata=sr_in -> CLR_SR.
REQ-018 CLR_SR: one cycle; rf_RW=1, rf_DA=2, rf_Din=sr_in & 16'hFF47 (clears GIE, CPUOFF, OSCOFF, SCG1); irq_ack[latched]=1 -> VEC_RD.
REQ-019 VEC_RD: mem_re=1, mem_addr=vector, held until mem_rdy; latch mem_rdata -> LOAD_PC.
REQ-020 LOAD_PC: one cycle; rf_RW=1, rf_DA=0, rf_Din=latched vector & 16'hFFFE -> IDLE.
REQ-021 POP_SR: mem_re=1, mem_addr=sp_in, until mem_rdy; that cycle writes R2=mem_rdata -> INC_SP1.
REQ-022 INC_SP1/INC_SP2: one cycle; write R1=sp_in+2; next POP_PC / IDLE respectively.
REQ-023 POP_PC: as POP_SR, writing R0=mem_rdata & 16'hFFFE -> INC_SP2.
REQ-024 SP arithmetic modulo 2^16 (0x0000-2 = 0xFFFE; 0xFFFE+2 = 0x0000).
REQ-025 At most one of mem_we/mem_re high per cycle; at most one rf_RW write per cycle; all strobes 0 in IDLE.
REQ-026 Request deasserting after acceptance does not abort; sequence completes with latched index and issues ack.
REQ-027 mem_rdy low for any number of cycles: state, address and data outputs held stable.

Reset
REQ-028 rst=0 at a clock edge: state IDLE, latched index 0, vector latch 0, all outputs 0 next cycle, regardless of current state; no partial register write follows.

Configuration
REQ-029 IRQ_NMI_EN defined: adds nmi_req in 1 and nmi_ack out 1; rising edge of nmi_req (registered) is pending until accepted, ignores GIE, outranks all irq_req but not reti_req, vector 16'hFFFC, nmi_ack pulses in CLR_SR.
REQ-030 IRQ_NMI_EN undefined: no nmi ports, edge register or pending logic.

Verification
REQ-031 sp=0x0400, pc=0xC010, sr=0x0008, irq_req=4'b0101, boundary=1, mem_rdy=1 -> writes 0xC010@0x03FE, 0x0008@0x03FC; SP=0x03FC; SR=0x0000; irq_ack=4'b0100; read 0xFFE4; PC=rdata&0xFFFE; 6 cycles.
REQ-032 Same with sr=0x0000 -> stays IDLE, no strobes, busy=0.
REQ-033 reti_req with sp=0x03FC, mem holds 0x0008, 0xC010 -> R2=0x0008, SP=0x03FE, R0=0xC010, SP=0x0400; busy 4 cycles.
REQ-034 mem_rdy low 3 cycles in PUSH_PC -> mem_addr/mem_wdata stable, no rf_RW until rdy.
REQ-035 rst=0 during VEC_RD -> IDLE next cycle, no R0 write, irq_ack 0.
REQ-036 (IRQ_NMI_EN) nmi_req rising, sr=0x0000, irq_req[3]=1 -> NMI sequence, read 0xFFFC, nmi_ack=1, irq_ack=0.
